cache_nway: RTL
===============

Name: cache_nway

Overview:
- Parametrised N-way set-associative, write-back, write-allocate data cache with an integrated miss controller.
- Sits between the CPU memory stage and a word-wide memory port.
- Generalises the fixed 2-way/32-set storage array to configurable ways, sets and line length.
- Adds true-LRU replacement, an internal request/ready handshake, dirty-line write-back and line-fill bursts, and a miss counter.

Parameters:
- ADDR_BITS, 32: address width.
- WAYS, 4: associativity; power of two, >=2.
- SETS, 32: number of sets; power of two.
- LINE_WORDS, 4: 32-bit words per line; power of two.
- Derived: IDX=log2(SETS), WOFF=log2(LINE_WORDS), TAG=ADDR_BITS-IDX-WOFF-2, AGE=log2(WAYS).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  access request; sampled only when cpu_busy=0.
- cpu_we  in  1  1=store, 0=load.
- cpu_addr  in  ADDR_BITS  byte address.
- cpu_u_b_h_w  in  3  [1:0] 00=byte, 01=half, 10=word; [2]=unsigned (loads only).
- cpu_din  in  32  store data, right-aligned.
- cpu_dout  out  32  load result, extended per cpu_u_b_h_w.
- cpu_ready  out  1  one-cycle pulse: access complete, cpu_dout valid.
- cpu_busy  out  1  1 while state != IDLE.
- mem_req  out  1  memory transfer active.
- mem_we  out  1  1=write-back word, 0=fill read.
- mem_addr  out  ADDR_BITS  word-aligned address of current beat.
- mem_dout  out  32  write-back data.
- mem_din  in  32  fill data, valid with mem_ack.
- mem_ack  in  1  one beat accepted/returned this cycle.
- miss_cnt  out  32  saturating count of tag misses.

Behaviour:
- Address split: tag=[ADDR_BITS-1:ADDR_BITS-TAG], index=next IDX bits, word=next WOFF bits, byte=[1:0].
- Misaligned half/word accesses are unsupported; the result is don't-care and the bench does not generate them.
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - All valid and dirty bits cleared.
  - Per-set age of way w = w.
  - All outputs 0, including miss_cnt.
  - Data and tag arrays are not reset.
  - A reset mid-burst abandons the transfer; the partially filled line stays invalid.
- FSM states: IDLE, TAG, WB, FILL.
- IDLE:
  - cpu_req=1 latches addr, we, u_b_h_w and din, then goes to TAG.
  - A request in the same cycle as cpu_ready is accepted.
- TAG, hit (valid and tag match in exactly one way):
  - Load: cpu_dout is registered from the selected word with byte/half extraction and sign/zero extension.
  - Store: byte/half/word is merged into the line word and dirty is set.
  - LRU update, then cpu_ready=1 for the next cycle and return to IDLE.
  - Hit latency: request cycle + 2 edges to the ready pulse.
- TAG, miss:
  - miss_cnt is incremented (saturates at all-ones).
  - Victim: lowest-index invalid way; otherwise the way with age = WAYS-1.
  - Victim valid and dirty -> WB with beat counter = 0; otherwise -> FILL with beat counter = 0.
- WB:
  - mem_req=1, mem_we=1.
  - mem_addr = {victim tag, index, beat, 2'b00}; mem_dout = victim word[beat].
  - Each mem_ack advances beat.
  - The ack on beat LINE_WORDS-1 clears victim dirty and goes to FILL with beat=0.
- FILL:
  - mem_req=1, mem_we=0, mem_addr = {req tag, index, beat, 2'b00}.
  - Each mem_ack writes mem_din into victim word[beat].
  - The last ack writes the tag, sets valid=1 and dirty=0, then returns to TAG. The re-lookup hits and is not counted as a miss.
- mem_req stays high across the WB->FILL boundary.
- mem_* outputs are decoded from state/counter registers only; there is no combinational path from mem_ack or mem_din.
- LRU on access to way w: every way whose age < age[w] increments, then age[w]=0. Ages remain a permutation of 0..WAYS-1.
- mem_ack while mem_req=0 is ignored. cpu_req while busy is ignored.

Test Plan (defaults; set stride 0x200):
- After reset, LW 0x040; memory returns 0x11111111, 0x22222222, 0x33333333, 0x44444444 -> fill reads 0x040, 0x044, 0x048, 0x04C; cpu_dout=0x11111111; miss_cnt=1. Then LW 0x044 -> ready 2 edges after request, cpu_dout=0x22222222, no mem_req.
- Line at 0x100 word0=0x80807F01:
  - LB 0x103 -> 0xFFFFFF80
  - LBU 0x103 -> 0x00000080
  - LH 0x102 -> 0xFFFF8080
  - LHU 0x100 -> 0x00007F01
- SB 0x101 din=0x000000AB, then LW 0x100 -> 0x8080AB01; no memory traffic; miss_cnt unchanged.
- LW 0x000, 0x200, 0x400, 0x600, then 0x000 again, then LW 0x800 -> victim is line 0x200; clean, so FILL only (no mem_we=1 beat). Next LW 0x000 hits.
- SW 0x200 din=0xDEADBEEF, then touch 0x000, 0x400, 0x600, then LW 0xA00 -> WB beats at 0x200..0x20C with the first mem_dout=0xDEADBEEF, then FILL 0xA00..0xA0C, then ready.
- Drive rst=0 after the 2nd fill ack of LW 0x040 -> all outputs 0 immediately. After release, LW 0x040 misses again and miss_cnt=1.

Source files
------------

// File: rtl/cache_nway_if.sv
// cache_nway_if: CPU-side request/ready and word-wide memory-side
// transfer signals of the cache bundled as one port.
interface cache_nway_if #(
  parameter int ADDR_BITS = 32
);
  logic                 cpu_req;
  logic                 cpu_we;
  logic [ADDR_BITS-1:0] cpu_addr;
  logic [2:0]           cpu_u_b_h_w;
  logic [31:0]          cpu_din;
  logic [31:0]          cpu_dout;
  logic                 cpu_ready;
  logic                 cpu_busy;
  logic                 mem_req;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [31:0]          mem_dout;
  logic [31:0]          mem_din;
  logic                 mem_ack;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr,
    input  cpu_u_b_h_w, cpu_din,
    input  mem_din, mem_ack,
    output cpu_dout, cpu_ready, cpu_busy,
    output mem_req, mem_we, mem_addr, mem_dout
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr,
    output cpu_u_b_h_w, cpu_din,
    output mem_din, mem_ack,
    input  cpu_dout, cpu_ready, cpu_busy,
    input  mem_req, mem_we, mem_addr, mem_dout
  );
endinterface

// File: rtl/cache_nway.sv
// cache_nway: N-way set-associative write-back, write-allocate data
// cache with true-LRU replacement and an integrated miss controller.
module cache_nway #(
  parameter int ADDR_BITS  = 32,
  parameter int WAYS       = 4,
  parameter int SETS       = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  cache_nway_if.slave bus,
  output logic [31:0] miss_cnt
);
  localparam int IDX  = $clog2(SETS);
  localparam int WOFF = $clog2(LINE_WORDS);
  localparam int TAGW = ADDR_BITS - IDX - WOFF - 2;
  localparam int AGE  = $clog2(WAYS);

  typedef enum logic [1:0] {
    S_IDLE, S_TAG, S_WB, S_FILL
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 we_q, we_d;
  logic [2:0]           ubhw_q, ubhw_d;
  logic [31:0]          din_q, din_d;
  logic [WOFF-1:0]      beat_q, beat_d;
  logic [AGE-1:0]       vic_q, vic_d;
  logic [31:0]          dout_q, dout_d;
  logic                 rdy_q, rdy_d;
  logic [31:0]          miss_q, miss_d;

  logic [WAYS-1:0] valid_q [SETS];
  logic [WAYS-1:0] valid_d [SETS];
  logic [WAYS-1:0] dirty_q [SETS];
  logic [WAYS-1:0] dirty_d [SETS];
  logic [AGE-1:0]  age_q [SETS][WAYS];
  logic [AGE-1:0]  age_d [SETS][WAYS];

  logic [TAGW-1:0] tag_mem [SETS][WAYS];
  logic [31:0]     data_mem [SETS][WAYS][LINE_WORDS];

  logic [TAGW-1:0] r_tag;
  logic [IDX-1:0]  r_idx;
  logic [WOFF-1:0] r_word;
  logic [1:0]      r_byte;

  assign r_tag  = addr_q[ADDR_BITS-1 -: TAGW];
  assign r_idx  = addr_q[WOFF+2 +: IDX];
  assign r_word = addr_q[2 +: WOFF];
  assign r_byte = addr_q[1:0];

  logic           hit;
  logic [AGE-1:0] hit_way;
  logic [AGE-1:0] vic;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[r_idx][w] &&
          tag_mem[r_idx][w] == r_tag) begin
        hit     = 1'b1;
        hit_way = AGE'(w);
      end
    end
  end

  // An invalid way always wins over the LRU way
  always_comb begin
    vic = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (age_q[r_idx][w] == AGE'(WAYS - 1))
        vic = AGE'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[r_idx][w])
        vic = AGE'(w);
    end
  end

  logic [31:0] hit_word;
  logic [31:0] shifted;
  logic [31:0] load_val;
  logic [31:0] bmask;
  logic [31:0] merged;
  logic [4:0]  sh;

  always_comb begin
    hit_word = data_mem[r_idx][hit_way][r_word];
    sh       = {r_byte, 3'b000};
    shifted  = hit_word >> sh;
    load_val = shifted;
    bmask    = '1;
    unique case (1'b1)
      ubhw_q[1:0] == 2'b00: begin
        load_val = {{24{shifted[7] & ~ubhw_q[2]}},
                    shifted[7:0]};
        bmask    = 32'h0000_00ff << sh;
      end
      ubhw_q[1:0] == 2'b01: begin
        load_val = {{16{shifted[15] & ~ubhw_q[2]}},
                    shifted[15:0]};
        bmask    = 32'h0000_ffff << sh;
      end
      default: ;
    endcase
    merged = (hit_word & ~bmask) | ((din_q << sh) & bmask);
  end

  logic            dw_en;
  logic [AGE-1:0]  dw_way;
  logic [WOFF-1:0] dw_word;
  logic [31:0]     dw_data;
  logic            tw_en;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    ubhw_d  = ubhw_q;
    din_d   = din_q;
    beat_d  = beat_q;
    vic_d   = vic_q;
    dout_d  = dout_q;
    rdy_d   = 1'b0;
    miss_d  = miss_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    age_d   = age_q;
    dw_en   = 1'b0;
    dw_way  = vic_q;
    dw_word = beat_q;
    dw_data = bus.mem_din;
    tw_en   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cpu_req) begin
          addr_d  = bus.cpu_addr;
          we_d    = bus.cpu_we;
          ubhw_d  = bus.cpu_u_b_h_w;
          din_d   = bus.cpu_din;
          state_d = S_TAG;
        end
      end
      S_TAG: begin
        if (hit) begin
          if (we_q) begin
            dw_en   = 1'b1;
            dw_way  = hit_way;
            dw_word = r_word;
            dw_data = merged;
            dirty_d[r_idx][hit_way] = 1'b1;
          end else begin
            dout_d = load_val;
          end
          for (int w = 0; w < WAYS; w++) begin
            if (age_q[r_idx][w] < age_q[r_idx][hit_way])
              age_d[r_idx][w] = age_q[r_idx][w] + 1'b1;
          end
          age_d[r_idx][hit_way] = '0;
          rdy_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          miss_d = (&miss_q) ? miss_q : miss_q + 32'd1;
          vic_d  = vic;
          beat_d = '0;
          if (valid_q[r_idx][vic] && dirty_q[r_idx][vic]) begin
            state_d = S_WB;
          end else begin
            valid_d[r_idx][vic] = 1'b0;
            dirty_d[r_idx][vic] = 1'b0;
            state_d = S_FILL;
          end
        end
      end
      S_WB: begin
        if (bus.mem_ack) begin
          beat_d = beat_q + 1'b1;
          if (&beat_q) begin
            dirty_d[r_idx][vic_q] = 1'b0;
            valid_d[r_idx][vic_q] = 1'b0;
            state_d = S_FILL;
          end
        end
      end
      S_FILL: begin
        if (bus.mem_ack) begin
          dw_en  = 1'b1;
          beat_d = beat_q + 1'b1;
          if (&beat_q) begin
            tw_en   = 1'b1;
            valid_d[r_idx][vic_q] = 1'b1;
            dirty_d[r_idx][vic_q] = 1'b0;
            state_d = S_TAG;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      ubhw_q  <= '0;
      din_q   <= '0;
      beat_q  <= '0;
      vic_q   <= '0;
      dout_q  <= '0;
      rdy_q   <= 1'b0;
      miss_q  <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < WAYS; w++)
          age_q[s][w] <= AGE'(w);
      end
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      ubhw_q  <= ubhw_d;
      din_q   <= din_d;
      beat_q  <= beat_d;
      vic_q   <= vic_d;
      dout_q  <= dout_d;
      rdy_q   <= rdy_d;
      miss_q  <= miss_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      age_q   <= age_d;
    end
  end

  always_ff @(posedge clk) begin
    if (dw_en)
      data_mem[r_idx][dw_way][dw_word] <= dw_data;
    if (tw_en)
      tag_mem[r_idx][vic_q] <= r_tag;
  end

  always_comb begin
    bus.mem_req  = 1'b0;
    bus.mem_we   = 1'b0;
    bus.mem_addr = '0;
    bus.mem_dout = '0;
    unique case (state_q)
      S_WB: begin
        bus.mem_req  = 1'b1;
        bus.mem_we   = 1'b1;
        bus.mem_addr = {tag_mem[r_idx][vic_q], r_idx,
                        beat_q, 2'b00};
        bus.mem_dout = data_mem[r_idx][vic_q][beat_q];
      end
      S_FILL: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = {r_tag, r_idx, beat_q, 2'b00};
      end
      default: ;
    endcase
  end

  assign bus.cpu_dout  = dout_q;
  assign bus.cpu_ready = rdy_q;
  assign bus.cpu_busy  = (state_q != S_IDLE);
  assign miss_cnt      = miss_q;
endmodule
